// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one framebuffer memory command port between the VGA display line
// fetcher (read bursts) and the pixel writer (write bursts). One command is
// issued per fixed-length burst and the data beats are counted to detect
// completion. Display wins ties while its scan-out FIFO is urgent, otherwise
// ties alternate round-robin.
// Optional feature: define VGA_ARB_STARVE_GUARD_EN to cap the number of
// consecutive display bursts granted while the writer is waiting.
module vga_fb_arbiter #(
  parameter int AW           = 32,
  parameter int BURST        = 16,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  input  logic          disp_urgent,
  output logic          disp_gnt,
  output logic          disp_done,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  output logic          wr_gnt,
  output logic          wr_done,
  output logic          mem_cmd_valid,
  input  logic          mem_cmd_ready,
  output logic          mem_cmd_write,
  output logic [AW-1:0] mem_cmd_addr,
  input  logic          mem_beat,
  output logic [1:0]    owner
);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BEAT_ONE  = CW'(1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST);
  localparam logic [1:0]    OWN_NONE  = 2'b00;
  localparam logic [1:0]    OWN_DISP  = 2'b01;
  localparam logic [1:0]    OWN_WR    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CMD   = 2'b01,
    ST_BURST = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] beat_next_s;
  logic          last_wr_q, last_wr_d;   // 1: the writer owned the last completed burst
  logic          valid_q, valid_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    owner_q, owner_d;
  logic          disp_gnt_q, disp_gnt_d;
  logic          disp_done_q, disp_done_d;
  logic          wr_gnt_q, wr_gnt_d;
  logic          wr_done_q, wr_done_d;
  logic          any_req_s;
  logic          pick_wr_s;
  logic          guard_hit_s;

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int RW = $clog2(MAX_DISP_RUN + 1);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DISP_RUN);

  logic [RW-1:0] run_cnt_q, run_cnt_d;

  // Count display bursts accepted back-to-back while the writer keeps asking.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!wr_req) begin
        run_cnt_d = '0;
      end else begin
        run_cnt_d = run_cnt_q;
      end
    end else if ((state_q == ST_CMD) && mem_cmd_ready) begin
      if (write_q) begin
        run_cnt_d = '0;
      end else if (wr_req && (run_cnt_q != RUN_MAX)) begin
        run_cnt_d = run_cnt_q + RUN_ONE;
      end else begin
        run_cnt_d = run_cnt_q;
      end
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Run counter register.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign guard_hit_s = wr_req && (run_cnt_q == RUN_MAX);
`else
  // Keeps the parameter list identical in both builds.
  localparam int unused_max_disp_run = MAX_DISP_RUN;
  assign guard_hit_s = 1'b0;
`endif

  assign any_req_s   = disp_req | wr_req;
  assign beat_next_s = beat_cnt_q + BEAT_ONE;

  // Choose the next burst owner: guard, lone requester, urgency, round-robin.
  always_comb begin
    pick_wr_s = 1'b0;
    if (guard_hit_s) begin
      pick_wr_s = 1'b1;
    end else if (disp_req && !wr_req) begin
      pick_wr_s = 1'b0;
    end else if (wr_req && !disp_req) begin
      pick_wr_s = 1'b1;
    end else if (disp_urgent) begin
      pick_wr_s = 1'b0;
    end else begin
      pick_wr_s = ~last_wr_q;
    end
  end

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    last_wr_d   = last_wr_q;
    valid_d     = valid_q;
    write_d     = write_q;
    addr_d      = addr_q;
    owner_d     = owner_q;
    disp_gnt_d  = 1'b0;
    disp_done_d = 1'b0;
    wr_gnt_d    = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_CMD;
          valid_d = 1'b1;
          write_d = pick_wr_s;
          addr_d  = pick_wr_s ? wr_addr : disp_addr;
          owner_d = pick_wr_s ? OWN_WR : OWN_DISP;
        end else begin
          valid_d = 1'b0;
          write_d = 1'b0;
          addr_d  = '0;
          owner_d = OWN_NONE;
        end
      end
      ST_CMD: begin
        if (mem_cmd_ready) begin
          state_d    = ST_BURST;
          valid_d    = 1'b0;
          beat_cnt_d = '0;
          disp_gnt_d = ~write_q;
          wr_gnt_d   = write_q;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_BURST: begin
        if (mem_beat && (beat_next_s == BEAT_LAST)) begin
          state_d     = ST_IDLE;
          beat_cnt_d  = beat_next_s;
          last_wr_d   = write_q;
          disp_done_d = ~write_q;
          wr_done_d   = write_q;
          write_d     = 1'b0;
          addr_d      = '0;
          owner_d     = OWN_NONE;
        end else if (mem_beat) begin
          beat_cnt_d = beat_next_s;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      last_wr_q   <= 1'b1;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      owner_q     <= OWN_NONE;
      disp_gnt_q  <= 1'b0;
      disp_done_q <= 1'b0;
      wr_gnt_q    <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      last_wr_q   <= last_wr_d;
      valid_q     <= valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      owner_q     <= owner_d;
      disp_gnt_q  <= disp_gnt_d;
      disp_done_q <= disp_done_d;
      wr_gnt_q    <= wr_gnt_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign mem_cmd_valid = valid_q;
  assign mem_cmd_write = write_q;
  assign mem_cmd_addr  = addr_q;
  assign owner         = owner_q;
  assign disp_gnt      = disp_gnt_q;
  assign disp_done     = disp_done_q;
  assign wr_gnt        = wr_gnt_q;
  assign wr_done       = wr_done_q;

endmodule
